// File: rtl/ct_ifu_bht_pkg.sv
// Shared definitions for the IFU BHT access path.
//  IDX_WIDTH / DATA_WIDTH : default array geometry (entry = taken[31:0] | ntake[31:0])
//  UPD_DEPTH / STARVE_MAX : default update-queue depth and read-starvation limit
//  bht_state_e            : access sequencer FSM encoding
package ct_ifu_bht_pkg;
   localparam int IDX_WIDTH  = 10;
   localparam int DATA_WIDTH = 64;
   localparam int UPD_DEPTH  = 2;
   localparam int STARVE_MAX = 4;

   typedef enum logic [1:0] {
      BHT_IDLE = 2'b00,
      BHT_INV  = 2'b01,
      BHT_DONE = 2'b10
   } bht_state_e;
endpackage

// File: rtl/ct_ifu_bht_upd_fifo.sv
// Update queue for resolved-branch BHT writes.
//  clk, rst_b         : clock, async active-low reset
//  push/push_idx/data : enqueue one update (caller guarantees ~full)
//  pop                : dequeue head (ignored when empty)
//  clr                : drop all entries; wins over push and pop
//  full/empty         : registered occupancy flags
//  head_idx/head_data : oldest entry
module ct_ifu_bht_upd_fifo #(
   parameter int DEPTH      = 2,
   parameter int IDX_WIDTH  = 10,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  clr,
   input  logic [IDX_WIDTH-1:0]  push_idx,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  full,
   output logic                  empty,
   output logic [IDX_WIDTH-1:0]  head_idx,
   output logic [DATA_WIDTH-1:0] head_data
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [IDX_WIDTH-1:0]  idx_mem  [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      cnt;
   logic                  do_push;
   logic                  do_pop;

   assign empty     = (cnt == '0);
   assign full      = (cnt == CNT_W'(DEPTH));
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign head_idx  = idx_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
         else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx_mem[i]  <= '0;
            data_mem[i] <= '0;
         end
      end else if (do_push && !clr) begin
         idx_mem[wr_ptr]  <= push_idx;
         data_mem[wr_ptr] <= push_data;
      end
   end
endmodule

// File: rtl/ct_ifu_bht_acc_ctrl.sv
// BHT pattern-array access sequencer. Shares the single array port between
// pcgen prediction reads, queued IU updates and the invalidate sweep.
//  forever_cpuclk, cpurst_b           : clock, async active-low reset
//  cp0_ifu_bht_en                     : BHT enable (0 blocks reads, drops updates)
//  ifctrl_bht_inv                     : invalidate request
//  bht_ifctrl_inv_on / inv_done       : sweep active / one-cycle completion pulse
//  pcgen_bht_rd_req / pcindex / rd_gnt: prediction read handshake
//  iu_bht_upd_vld / idx / data / rdy  : update push handshake
//  bht_arr_cen / wen / idx / wdata    : array port (combinational from state)
module ct_ifu_bht_acc_ctrl #(
   parameter int IDX_WIDTH  = ct_ifu_bht_pkg::IDX_WIDTH,
   parameter int DATA_WIDTH = ct_ifu_bht_pkg::DATA_WIDTH,
   parameter int UPD_DEPTH  = ct_ifu_bht_pkg::UPD_DEPTH,
   parameter int STARVE_MAX = ct_ifu_bht_pkg::STARVE_MAX
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  cp0_ifu_bht_en,
   input  logic                  ifctrl_bht_inv,
   output logic                  bht_ifctrl_inv_on,
   output logic                  bht_ifctrl_inv_done,
   input  logic                  pcgen_bht_rd_req,
   input  logic [IDX_WIDTH-1:0]  pcgen_bht_pcindex,
   output logic                  bht_pcgen_rd_gnt,
   input  logic                  iu_bht_upd_vld,
   input  logic [IDX_WIDTH-1:0]  iu_bht_upd_idx,
   input  logic [DATA_WIDTH-1:0] iu_bht_upd_data,
   output logic                  bht_iu_upd_rdy,
   output logic                  bht_arr_cen,
   output logic                  bht_arr_wen,
   output logic [IDX_WIDTH-1:0]  bht_arr_idx,
   output logic [DATA_WIDTH-1:0] bht_arr_wdata
);
   import ct_ifu_bht_pkg::*;

   localparam int ST_W = $clog2(STARVE_MAX + 1);

   bht_state_e            state;
   bht_state_e            next_state;
   logic [IDX_WIDTH-1:0]  sweep_cnt;
   logic [ST_W-1:0]       starve_cnt;
   logic                  idle;
   logic                  force_wr;
   logic                  rd_win;
   logic                  pop;
   logic                  push;
   logic                  clr;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [IDX_WIDTH-1:0]  head_idx;
   logic [DATA_WIDTH-1:0] head_data;

   assign idle     = (state == BHT_IDLE);
   assign force_wr = (starve_cnt == ST_W'(STARVE_MAX)) & fifo_full;
   assign rd_win   = idle & pcgen_bht_rd_req & cp0_ifu_bht_en & ~force_wr;
   assign pop      = idle & cp0_ifu_bht_en & ~rd_win & ~fifo_empty;
   // While disabled the queue is held clear, so a push is acknowledged but lost.
   assign push     = iu_bht_upd_vld & bht_iu_upd_rdy & cp0_ifu_bht_en;
   assign clr      = idle & (ifctrl_bht_inv | ~cp0_ifu_bht_en);

   ct_ifu_bht_upd_fifo #(
      .DEPTH      (UPD_DEPTH),
      .IDX_WIDTH  (IDX_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_upd_fifo (
      .clk       (forever_cpuclk),
      .rst_b     (cpurst_b),
      .push      (push),
      .pop       (pop),
      .clr       (clr),
      .push_idx  (iu_bht_upd_idx),
      .push_data (iu_bht_upd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_idx  (head_idx),
      .head_data (head_data)
   );

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) state <= BHT_IDLE;
      else           state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         BHT_IDLE: if (ifctrl_bht_inv) next_state = BHT_INV;
         BHT_INV:  if (sweep_cnt == '1) next_state = BHT_DONE;
         BHT_DONE: next_state = BHT_IDLE;
         default:  next_state = BHT_IDLE;
      endcase
   end

   always_comb begin
      bht_ifctrl_inv_on   = (state == BHT_INV);
      bht_ifctrl_inv_done = (state == BHT_DONE);
      bht_pcgen_rd_gnt    = rd_win;
      bht_iu_upd_rdy      = idle & (~fifo_full | ~cp0_ifu_bht_en);
      bht_arr_cen         = 1'b0;
      bht_arr_wen         = 1'b0;
      bht_arr_idx         = '0;
      bht_arr_wdata       = '0;
      if (state == BHT_INV) begin
         bht_arr_cen = 1'b1;
         bht_arr_wen = 1'b1;
         bht_arr_idx = sweep_cnt;
      end else if (rd_win) begin
         bht_arr_cen = 1'b1;
         bht_arr_idx = pcgen_bht_pcindex;
      end else if (pop) begin
         bht_arr_cen   = 1'b1;
         bht_arr_wen   = 1'b1;
         bht_arr_idx   = head_idx;
         bht_arr_wdata = head_data;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b)                       sweep_cnt <= '0;
      else if (idle && ifctrl_bht_inv)     sweep_cnt <= '0;
      else if (state == BHT_INV)           sweep_cnt <= sweep_cnt + IDX_WIDTH'(1);
   end

   // Counts reads that beat a full queue; once saturated, the next slot goes to the write.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b)
         starve_cnt <= '0;
      else if (!idle || pop || !fifo_full)
         starve_cnt <= '0;
      else if (rd_win && starve_cnt != ST_W'(STARVE_MAX))
         starve_cnt <= starve_cnt + ST_W'(1);
   end
endmodule

// File: tb/tb_ct_ifu_bht_acc_ctrl.sv
module tb_ct_ifu_bht_acc_ctrl;
   logic        clk;
   logic        rst_b;
   logic        bht_en;
   logic        inv;
   logic        inv_on;
   logic        inv_done;
   logic        rd_req;
   logic [9:0]  pcindex;
   logic        rd_gnt;
   logic        upd_vld;
   logic [9:0]  upd_idx;
   logic [63:0] upd_data;
   logic        upd_rdy;
   logic        cen;
   logic        wen;
   logic [9:0]  aidx;
   logic [63:0] wdata;

   int n_chk = 0;
   int n_bad = 0;

   ct_ifu_bht_acc_ctrl dut (
      .forever_cpuclk      (clk),
      .cpurst_b            (rst_b),
      .cp0_ifu_bht_en      (bht_en),
      .ifctrl_bht_inv      (inv),
      .bht_ifctrl_inv_on   (inv_on),
      .bht_ifctrl_inv_done (inv_done),
      .pcgen_bht_rd_req    (rd_req),
      .pcgen_bht_pcindex   (pcindex),
      .bht_pcgen_rd_gnt    (rd_gnt),
      .iu_bht_upd_vld      (upd_vld),
      .iu_bht_upd_idx      (upd_idx),
      .iu_bht_upd_data     (upd_data),
      .bht_iu_upd_rdy      (upd_rdy),
      .bht_arr_cen         (cen),
      .bht_arr_wen         (wen),
      .bht_arr_idx         (aidx),
      .bht_arr_wdata       (wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs change 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // let combinational outputs settle before sampling
   task automatic settle();
      #2;
   endtask

   // sample after settle: all outputs at their idle/reset values
   task automatic chk_quiet(input string tag);
      chk({tag, "_inv_on"},   inv_on,   1'b0);
      chk({tag, "_inv_done"}, inv_done, 1'b0);
      chk({tag, "_rd_gnt"},   rd_gnt,   1'b0);
      chk({tag, "_upd_rdy"},  upd_rdy,  1'b1);
      chk({tag, "_cen"},      cen,      1'b0);
      chk({tag, "_wen"},      wen,      1'b0);
      chk({tag, "_idx"},      aidx,     10'h0);
      chk({tag, "_wdata"},    wdata,    64'h0);
   endtask

   // run a whole sweep from the first INV cycle; count cycles that deviate
   task automatic run_sweep(input int ncyc, output int errs);
      errs = 0;
      for (int i = 0; i < ncyc; i++) begin
         settle();
         if (cen !== 1'b1 || wen !== 1'b1 || aidx !== i[9:0] || wdata !== 64'h0 ||
             inv_on !== 1'b1 || inv_done !== 1'b0 || rd_gnt !== 1'b0 || upd_rdy !== 1'b0)
            errs++;
         tick();
      end
   endtask

   initial begin
      int errs;
      rst_b    = 1'b0;
      bht_en   = 1'b1;
      inv      = 1'b0;
      rd_req   = 1'b0;
      pcindex  = 10'h0;
      upd_vld  = 1'b0;
      upd_idx  = 10'h0;
      upd_data = 64'h0;
      repeat (3) tick();
      settle();
      chk_quiet("rst");
      rst_b = 1'b1;
      tick();

      // full invalidate sweep
      inv = 1'b1;
      settle();
      chk("t1_pre_inv_on", inv_on, 1'b0);
      tick();
      inv = 1'b0;
      settle();
      chk("t1_first_idx", aidx, 10'h0);
      run_sweep(1024, errs);
      chk("t1_sweep_seq", errs, 0);
      settle();
      chk("t1_done", inv_done, 1'b1);
      chk("t1_done_inv_on", inv_on, 1'b0);
      chk("t1_done_cen", cen, 1'b0);
      tick();
      settle();
      chk("t1_done_pulse_end", inv_done, 1'b0);
      chk("t1_idle_rdy", upd_rdy, 1'b1);

      // single update with no read traffic
      upd_vld = 1'b1; upd_idx = 10'h25; upd_data = 64'hA5;
      settle();
      chk("t2_push_rdy", upd_rdy, 1'b1);
      chk("t2_push_cen", cen, 1'b0);
      tick();
      upd_vld = 1'b0;
      settle();
      chk("t2_wr_cen", cen, 1'b1);
      chk("t2_wr_wen", wen, 1'b1);
      chk("t2_wr_idx", aidx, 10'h25);
      chk("t2_wr_data", wdata, 64'hA5);
      chk("t2_wr_rdy", upd_rdy, 1'b1);
      tick();
      settle();
      chk("t2_after_cen", cen, 1'b0);

      // read starvation of a full queue
      rd_req = 1'b1; pcindex = 10'h3FF;
      upd_vld = 1'b1; upd_idx = 10'h11; upd_data = 64'h111;
      settle();
      chk("t3_a_gnt", rd_gnt, 1'b1);
      tick();
      upd_idx = 10'h22; upd_data = 64'h222;
      settle();
      chk("t3_b_rdy", upd_rdy, 1'b1);
      chk("t3_b_gnt", rd_gnt, 1'b1);
      tick();
      upd_vld = 1'b0;
      settle();
      chk("t3_full_rdy", upd_rdy, 1'b0);
      chk("t3_rd_idx", aidx, 10'h3FF);
      chk("t3_rd_wen", wen, 1'b0);
      errs = 0;
      for (int i = 0; i < 4; i++) begin
         settle();
         if (rd_gnt !== 1'b1 || cen !== 1'b1 || wen !== 1'b0) errs++;
         tick();
      end
      chk("t3_four_reads", errs, 0);
      settle();
      chk("t3_forced_gnt", rd_gnt, 1'b0);
      chk("t3_forced_cen", cen, 1'b1);
      chk("t3_forced_wen", wen, 1'b1);
      chk("t3_forced_idx", aidx, 10'h11);
      chk("t3_forced_data", wdata, 64'h111);
      tick();
      settle();
      chk("t3_resume_gnt", rd_gnt, 1'b1);
      chk("t3_resume_rdy", upd_rdy, 1'b1);
      tick();
      rd_req = 1'b0;
      settle();
      chk("t3_drain_idx", aidx, 10'h22);
      chk("t3_drain_data", wdata, 64'h222);
      tick();
      settle();
      chk("t3_empty_cen", cen, 1'b0);

      // invalidate discards queued updates
      rd_req = 1'b1; pcindex = 10'h100;
      upd_vld = 1'b1; upd_idx = 10'h44; upd_data = 64'h444;
      tick();
      upd_idx = 10'h55; upd_data = 64'h555;
      tick();
      upd_vld = 1'b0;
      inv = 1'b1;
      settle();
      chk("t4_full_rdy", upd_rdy, 1'b0);
      tick();
      inv = 1'b0;
      settle();
      chk("t4_inv_rdy", upd_rdy, 1'b0);
      chk("t4_inv_gnt", rd_gnt, 1'b0);
      run_sweep(1024, errs);
      chk("t4_sweep_seq", errs, 0);
      rd_req = 1'b0;
      settle();
      chk("t4_done", inv_done, 1'b1);
      tick();
      settle();
      chk("t4_idle_cen", cen, 1'b0);
      chk("t4_idle_rdy", upd_rdy, 1'b1);
      tick();
      settle();
      chk("t4_idle_cen2", cen, 1'b0);

      // disabled BHT
      bht_en = 1'b0; rd_req = 1'b1; pcindex = 10'h7;
      upd_vld = 1'b1; upd_idx = 10'h33; upd_data = 64'h333;
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         if (rd_gnt !== 1'b0 || cen !== 1'b0 || upd_rdy !== 1'b1) errs++;
         tick();
      end
      chk("t5_disabled", errs, 0);
      bht_en = 1'b1; rd_req = 1'b0; upd_vld = 1'b0;
      settle();
      chk("t5_reen_cen", cen, 1'b0);
      tick();
      settle();
      chk("t5_reen_cen2", cen, 1'b0);

      // reset in the middle of a sweep
      inv = 1'b1;
      tick();
      inv = 1'b0;
      repeat (500) tick();
      settle();
      chk("t6_idx500", aidx, 10'd500);
      rst_b = 1'b0;
      #1;
      chk_quiet("t6_rst");
      errs = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         if (inv_done !== 1'b0 || inv_on !== 1'b0) errs++;
      end
      rst_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         if (inv_done !== 1'b0 || inv_on !== 1'b0) errs++;
      end
      chk("t6_no_done", errs, 0);
      tick();
      inv = 1'b1;
      tick();
      inv = 1'b0;
      settle();
      chk("t6_restart_on", inv_on, 1'b1);
      chk("t6_restart_idx", aidx, 10'h0);
      tick();
      settle();
      chk("t6_restart_idx1", aidx, 10'h1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
